// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error flag
// Ports: i_Clock (rising-edge clock), i_Rst_n (sync active-low reset), i_Rx_Serial (async line, idle high),
//        o_Rx_DV (1-cycle good-byte pulse), o_Rx_Byte (last good byte), o_Rx_Active (frame in progress),
//        o_Frame_Err (1-cycle pulse, stop bit sampled low)
module uart_rx #(
    parameter int CLKS_PER_BIT = 5000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t        r_State, w_State;
    logic          r_Sync1, r_Rx;
    logic [1:0]    r_Settle;
    logic [CW-1:0] r_Clock_Count, w_Clock_Count;
    logic [2:0]    r_Bit_Index, w_Bit_Index;
    logic [7:0]    r_Shift, w_Shift, w_Rx_Byte;
    logic          w_Rx_DV, w_Frame_Err;

    // r_Settle holds WAIT_HIGH until the synchronizer carries a real line sample,
    // so a line that is low at reset release is not mistaken for idle
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_Sync1       <= 1'b1;
            r_Rx          <= 1'b1;
            r_Settle      <= '0;
            r_State       <= WAIT_HIGH;
            r_Clock_Count <= '0;
            r_Bit_Index   <= '0;
            r_Shift       <= '0;
            o_Rx_Byte     <= '0;
            o_Rx_DV       <= 1'b0;
            o_Frame_Err   <= 1'b0;
        end else begin
            r_Sync1       <= i_Rx_Serial;
            r_Rx          <= r_Sync1;
            r_Settle      <= {r_Settle[0], 1'b1};
            r_State       <= w_State;
            r_Clock_Count <= w_Clock_Count;
            r_Bit_Index   <= w_Bit_Index;
            r_Shift       <= w_Shift;
            o_Rx_Byte     <= w_Rx_Byte;
            o_Rx_DV       <= w_Rx_DV;
            o_Frame_Err   <= w_Frame_Err;
        end
    end

    always_comb begin
        w_State       = r_State;
        w_Clock_Count = r_Clock_Count;
        w_Bit_Index   = r_Bit_Index;
        w_Shift       = r_Shift;
        w_Rx_Byte     = o_Rx_Byte;
        w_Rx_DV       = 1'b0;
        w_Frame_Err   = 1'b0;
        case (r_State)
            WAIT_HIGH: begin
                w_Clock_Count = '0;
                w_Bit_Index   = '0;
                w_State       = (r_Rx && r_Settle[1]) ? IDLE : WAIT_HIGH;
            end
            IDLE: begin
                w_Clock_Count = '0;
                w_Bit_Index   = '0;
                w_State       = r_Rx ? IDLE : START;
            end
            START: begin
                if (r_Clock_Count == HALF) begin
                    w_Clock_Count = '0;
                    w_State       = r_Rx ? IDLE : DATA;
                end else begin
                    w_Clock_Count = r_Clock_Count + 1'b1;
                end
            end
            DATA: begin
                if (r_Clock_Count == LAST) begin
                    w_Clock_Count          = '0;
                    w_Shift[r_Bit_Index]   = r_Rx;
                    w_Bit_Index            = r_Bit_Index + 1'b1;
                    w_State                = (r_Bit_Index == 3'd7) ? STOP : DATA;
                end else begin
                    w_Clock_Count = r_Clock_Count + 1'b1;
                end
            end
            STOP: begin
                if (r_Clock_Count == LAST) begin
                    w_Clock_Count = '0;
                    w_Rx_Byte     = r_Rx ? r_Shift : o_Rx_Byte;
                    w_Rx_DV       = r_Rx;
                    w_Frame_Err   = !r_Rx;
                    w_State       = r_Rx ? CLEANUP : WAIT_HIGH;
                end else begin
                    w_Clock_Count = r_Clock_Count + 1'b1;
                end
            end
            CLEANUP: w_State = IDLE;
            default: w_State = WAIT_HIGH;
        endcase
    end

    assign o_Rx_Active = (r_State == START) || (r_State == DATA) || (r_State == STOP);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (table vectors, directed corner cases, random frames)
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx16 = 1'b1;
    logic       rx4 = 1'b1;
    logic       dv16, act16, err16, dv4, act4, err4;
    logic [7:0] byte16, byte4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_e0 = 0;
    int act_cnt = 0;
    bit watch_act = 0;
    logic [7:0] last_good = 8'h00;

    int         exp_dv_cyc[$], obs_dv_cyc[$], exp_err_cyc[$], obs_err_cyc[$];
    logic [7:0] exp_dv_byte[$], obs_dv_byte[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_after;
        int         high_after;
        logic       exp_dv;
        logic       exp_err;
        logic [7:0] exp_byte;
    } vec_t;
    vec_t tbl[5];

    uart_rx #(.CLKS_PER_BIT(16)) u16 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx16),
        .o_Rx_DV(dv16), .o_Rx_Byte(byte16), .o_Rx_Active(act16), .o_Frame_Err(err16)
    );
    uart_rx #(.CLKS_PER_BIT(4)) u4 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx4),
        .o_Rx_DV(dv4), .o_Rx_Byte(byte4), .o_Rx_Active(act4), .o_Frame_Err(err4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int cpb);
        return 3 + (cpb - 1) / 2 + 9 * cpb;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dv16) begin obs_dv_cyc.push_back(cyc); obs_dv_byte.push_back(byte16); end
        if (dv4) begin obs_dv_cyc.push_back(cyc); obs_dv_byte.push_back(byte4); end
        if (err16 || err4) obs_err_cyc.push_back(cyc);
        if (act16 || act4) act_cnt++;
        if (watch_act) begin
            if (cyc - cur_e0 == 1) check("active before E2", act16, 1'b0);
            if (cyc - cur_e0 == 2) check("active after E2", act16, 1'b1);
            if (cyc - cur_e0 == lat(16) - 1) check("active before DV", act16, 1'b1);
            if (cyc - cur_e0 == lat(16)) check("active falls with DV", act16, 1'b0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) rx4 = b; else rx16 = b;
    endtask

    task automatic send_frame(input int cpb, input bit sel, input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        cur_e0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            drive(sel, bits[i]);
            idle(cpb);
        end
    endtask

    task automatic expect_frame(input int cpb, input logic [7:0] d, input logic stop);
        if (stop) begin
            exp_dv_cyc.push_back(cur_e0 + lat(cpb));
            exp_dv_byte.push_back(d);
            last_good = d;
        end else begin
            exp_err_cyc.push_back(cur_e0 + lat(cpb));
        end
    endtask

    task automatic score(input string tag);
        check({tag, " dv count"}, obs_dv_cyc.size(), exp_dv_cyc.size());
        check({tag, " err count"}, obs_err_cyc.size(), exp_err_cyc.size());
        while (exp_dv_cyc.size() > 0 && obs_dv_cyc.size() > 0) begin
            check({tag, " dv cycle"}, obs_dv_cyc.pop_front(), exp_dv_cyc.pop_front());
            check({tag, " dv byte"}, obs_dv_byte.pop_front(), exp_dv_byte.pop_front());
        end
        while (exp_err_cyc.size() > 0 && obs_err_cyc.size() > 0)
            check({tag, " err cycle"}, obs_err_cyc.pop_front(), exp_err_cyc.pop_front());
        exp_dv_cyc.delete(); exp_dv_byte.delete(); exp_err_cyc.delete();
        obs_dv_cyc.delete(); obs_dv_byte.delete(); obs_err_cyc.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       st;
        int         gap;
        tbl[0] = '{8'h00, 1'b1, 0, 0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{8'hFF, 1'b1, 0, 20, 1'b1, 1'b0, 8'hFF};
        tbl[2] = '{8'hA5, 1'b1, 0, 20, 1'b1, 1'b0, 8'hA5};
        tbl[3] = '{8'h3C, 1'b0, 40, 10, 1'b0, 1'b1, 8'hA5};
        tbl[4] = '{8'h5A, 1'b1, 0, 20, 1'b1, 1'b0, 8'h5A};

        @(negedge clk);
        idle(3);
        check("reset dv", dv16, 1'b0);
        check("reset err", err16, 1'b0);
        check("reset active", act16, 1'b0);
        check("reset byte", byte16, 8'h00);
        rst_n = 1'b1;
        idle(10);

        watch_act = 1;
        send_frame(16, 0, 8'hA5, 1'b1);
        expect_frame(16, 8'hA5, 1'b1);
        idle(30);
        watch_act = 0;
        score("single A5");

        for (int v = 0; v < 5; v++) begin
            send_frame(16, 0, tbl[v].data, tbl[v].stop);
            if (tbl[v].exp_dv) begin
                exp_dv_cyc.push_back(cur_e0 + lat(16));
                exp_dv_byte.push_back(tbl[v].exp_byte);
            end
            if (tbl[v].exp_err) exp_err_cyc.push_back(cur_e0 + lat(16));
            if (tbl[v].low_after > 0) begin
                act_cnt = 0;
                idle(tbl[v].low_after);
                check("no restart while low", act_cnt, 0);
            end
            drive(0, 1'b1);
            idle(tbl[v].high_after);
            check("table byte held", byte16, tbl[v].exp_byte);
            if (v == 1)
                check("back-to-back spacing", obs_dv_cyc.size() >= 2 ? obs_dv_cyc[1] - obs_dv_cyc[0] : -1, 160);
        end
        last_good = 8'h5A;
        idle(30);
        score("table");

        act_cnt = 0;
        rx16 = 1'b0;
        idle(4);
        rx16 = 1'b1;
        idle(30);
        check("glitch saw active", act_cnt > 0, 1'b1);
        check("glitch back idle", act16, 1'b0);
        send_frame(16, 0, 8'h3C, 1'b1);
        expect_frame(16, 8'h3C, 1'b1);
        idle(30);
        score("glitch");

        rx16 = 1'b0;
        idle(16);
        rx16 = 1'b1;
        idle(16 * 3 + 5);
        rx16 = 1'b0;
        rst_n = 1'b0;
        idle(2);
        check("midreset dv", dv16, 1'b0);
        check("midreset active", act16, 1'b0);
        check("midreset byte", byte16, 8'h00);
        rst_n = 1'b1;
        last_good = 8'h00;
        act_cnt = 0;
        idle(40);
        check("no frame after reset low", act_cnt, 0);
        check("byte after reset", byte16, 8'h00);
        rx16 = 1'b1;
        idle(10);
        send_frame(16, 0, 8'h81, 1'b1);
        expect_frame(16, 8'h81, 1'b1);
        idle(30);
        score("reset");

        for (int k = 0; k < 40; k++) begin
            d = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            send_frame(16, 0, d, st);
            expect_frame(16, d, st);
            if (!st) begin
                idle($urandom_range(0, 20));
                rx16 = 1'b1;
                gap = $urandom_range(2, 12);
            end else begin
                gap = $urandom_range(0, 12);
            end
            idle(gap);
        end
        idle(40);
        score("random");
        check("random byte held", byte16, last_good);

        send_frame(4, 1, 8'h96, 1'b1);
        expect_frame(4, 8'h96, 1'b1);
        idle(20);
        score("cpb4");
        check("cpb4 byte", byte4, 8'h96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
